stack_ctrl_unit: RTL and testbench

Parametrised control unit for the stack processor. It fetches OPC_W+ADDR_W instructions from instruction ROM and sequences the data RAM, operand stack and external ALU. Both memories use req/ready handshakes. It tracks the stack pointer internally, detects overflow and underflow, and supports direct or indirect branches plus a HALT opcode. It sits between the program ROM, data RAM, stack RAM and ALU, and replaces the fixed 16-bit/5-bit sequencer.

---
 rtl/stack_ctrl_pkg.sv | 34 +++
 rtl/stack_ctrl_decode.sv | 34 +++
 rtl/stack_ctrl_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_stack_ctrl_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack processor control unit: opcode map,
// sequencer states, opcode classes and the operand-pop helper.
package stack_ctrl_pkg;

  localparam int unsigned OP_PUSH   = 0;
  localparam int unsigned OP_PUSH_I = 1;
  localparam int unsigned OP_PUSH_T = 2;
  localparam int unsigned OP_POP    = 3;
  localparam int unsigned OP_ALU_LO = 4;
  localparam int unsigned OP_ALU_HI = 12;
  localparam int unsigned OP_NOT    = 13;
  localparam int unsigned OP_GOTO   = 14;
  localparam int unsigned OP_BR_LO  = 15;
  localparam int unsigned OP_BR_HI  = 19;
  localparam int unsigned OP_HALT   = 31;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_POP_A, S_POP_B,
    S_EXEC, S_WB, S_BR, S_PUSH_W, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_PUSH_M, C_PUSH_I, C_PUSH_T, C_POP_M, C_BIN, C_NOT,
    C_GOTO, C_COND, C_HALT, C_ILL
  } op_class_t;

  // Number of stack entries an opcode consumes before it can proceed.
  function automatic logic [1:0] needed_pops(input int unsigned op);
    if (op >= OP_ALU_LO && op <= OP_ALU_HI) return 2'd2;
    if (op == OP_POP || op == OP_NOT || (op >= OP_BR_LO && op <= OP_BR_HI)) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational opcode classifier: class, pops needed, push flag, legality.
module stack_ctrl_decode
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        op_class,
  output logic [1:0]       pops,
  output logic             push,
  output logic             legal
);

  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  // Map the opcode onto its execution class.
  always_comb begin
    op_class = C_ILL;
    if (op_ext == OP_PUSH)                              op_class = C_PUSH_M;
    else if (op_ext == OP_PUSH_I)                       op_class = C_PUSH_I;
    else if (op_ext == OP_PUSH_T)                       op_class = C_PUSH_T;
    else if (op_ext == OP_POP)                          op_class = C_POP_M;
    else if (op_ext >= OP_ALU_LO && op_ext <= OP_ALU_HI) op_class = C_BIN;
    else if (op_ext == OP_NOT)                          op_class = C_NOT;
    else if (op_ext == OP_GOTO)                         op_class = C_GOTO;
    else if (op_ext >= OP_BR_LO && op_ext <= OP_BR_HI)  op_class = C_COND;
    else if (op_ext == OP_HALT)                         op_class = C_HALT;
    push  = (op_class == C_PUSH_M) || (op_class == C_PUSH_I) || (op_class == C_PUSH_T);
    legal = (op_class != C_ILL);
    pops  = needed_pops(op_ext);
  end

endmodule

// File: rtl/stack_ctrl_unit.sv
// Stack processor sequencer: fetches {opcode, operand} from ROM and drives
// data RAM, operand stack and ALU with stack-depth checking.
module stack_ctrl_unit
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned OPC_W           = 5,
  parameter int unsigned STACK_DEPTH     = 16,
  parameter int unsigned BRANCH_INDIRECT = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             rom_req,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic                             rom_ready,
  input  logic [OPC_W+ADDR_W-1:0]          rom_data,
  output logic                             ram_req,
  output logic                             ram_we,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [DATA_W-1:0]                ram_wdata,
  input  logic [DATA_W-1:0]                ram_rdata,
  input  logic                             ram_ready,
  output logic                             stk_push,
  output logic                             stk_pop,
  output logic [DATA_W-1:0]                stk_wdata,
  input  logic [DATA_W-1:0]                stk_rdata,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stk_ptr,
  output logic [OPC_W-1:0]                 alu_op,
  output logic [DATA_W-1:0]                alu_a,
  output logic [DATA_W-1:0]                alu_b,
  input  logic [DATA_W-1:0]                alu_result,
  input  logic                             alu_flag,
  output logic                             halted,
  output logic                             fault
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH+1);
  localparam int unsigned IW   = OPC_W + ADDR_W;
  localparam bit          IND  = (BRANCH_INDIRECT != 0);

  state_t              state, nstate;
  logic [ADDR_W-1:0]   pc;
  logic [SP_W-1:0]     sp;
  logic [IW-1:0]       instr;
  logic [DATA_W-1:0]   a_reg, b_reg, temp;
  logic                wr_lat;
  logic                halted_q, fault_q;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  op_class_t           cls;
  logic [1:0]          pops;
  logic                push_type, legal;

  assign opcode  = instr[IW-1:ADDR_W];
  assign operand = instr[ADDR_W-1:0];
  assign stk_ptr = sp;
  assign halted  = halted_q;
  assign fault   = fault_q;

  stack_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode   (opcode),
    .op_class (cls),
    .pops     (pops),
    .push     (push_type),
    .legal    (legal)
  );

  // State register and sticky status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state <= nstate;
      if (nstate == S_HALT)  halted_q <= 1'b1;
      if (nstate == S_FAULT) fault_q  <= 1'b1;
    end
  end

  // Datapath: pc, stack pointer, instruction, operand and temp registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= '0;
      sp     <= '0;
      instr  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      temp   <= '0;
      wr_lat <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (rom_ready) instr <= rom_data;
        S_DECODE: a_reg <= (cls == C_PUSH_T) ? temp : DATA_W'(operand);
        S_MEM_RD: if (ram_ready) begin
          a_reg <= ram_rdata;
          if (cls == C_COND) pc <= ram_rdata[ADDR_W-1:0];
        end
        // Popped value arrives one cycle after the pop; capture it on the
        // first MEM_WR cycle and replay it from a_reg while ram_req waits.
        S_MEM_WR: begin
          if (!wr_lat) begin
            a_reg  <= stk_rdata;
            wr_lat <= 1'b1;
          end
          if (ram_ready) begin
            pc     <= pc + 1'b1;
            wr_lat <= 1'b0;
          end
        end
        S_POP_A:  sp <= sp - 1'b1;
        S_POP_B: begin
          sp    <= sp - 1'b1;
          b_reg <= stk_rdata;
        end
        S_EXEC: begin
          a_reg <= stk_rdata;
          if (cls != C_BIN) b_reg <= '0;
        end
        S_WB: begin
          sp   <= sp + 1'b1;
          temp <= alu_result;
          pc   <= pc + 1'b1;
        end
        S_PUSH_W: begin
          sp <= sp + 1'b1;
          pc <= pc + 1'b1;
        end
        S_BR: begin
          if (cls == C_GOTO)  pc <= IND ? a_reg[ADDR_W-1:0] : operand;
          else if (!alu_flag) pc <= pc + 1'b1;
          else if (!IND)      pc <= operand;
        end
        default: ;
      endcase
    end
  end

  // Next-state sequencing including the stack depth checks in DECODE.
  always_comb begin
    nstate = state;
    case (state)
      S_FETCH:  if (rom_ready) nstate = S_DECODE;
      S_DECODE: begin
        if (!legal)                                  nstate = S_FAULT;
        else if (cls == C_HALT)                      nstate = S_HALT;
        else if (push_type && sp == SP_W'(STACK_DEPTH)) nstate = S_FAULT;
        else if (sp < SP_W'(pops))                   nstate = S_FAULT;
        else begin
          case (cls)
            C_PUSH_M:           nstate = S_MEM_RD;
            C_PUSH_I, C_PUSH_T: nstate = S_PUSH_W;
            C_GOTO:             nstate = IND ? S_MEM_RD : S_BR;
            default:            nstate = S_POP_A;
          endcase
        end
      end
      S_MEM_RD: if (ram_ready) begin
        if (cls == C_PUSH_M)    nstate = S_PUSH_W;
        else if (cls == C_GOTO) nstate = S_BR;
        else                    nstate = S_FETCH;
      end
      S_MEM_WR: if (ram_ready) nstate = S_FETCH;
      S_POP_A: begin
        if (cls == C_POP_M)    nstate = S_MEM_WR;
        else if (cls == C_BIN) nstate = S_POP_B;
        else                   nstate = S_EXEC;
      end
      S_POP_B:  nstate = S_EXEC;
      S_EXEC:   nstate = (cls == C_COND) ? S_BR : S_WB;
      S_WB:     nstate = S_FETCH;
      S_PUSH_W: nstate = S_FETCH;
      S_BR:     nstate = (cls == C_COND && alu_flag && IND) ? S_MEM_RD : S_FETCH;
      default:  nstate = state;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    rom_req   = 1'b0;
    rom_addr  = '0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          rom_req  = 1'b1;
          rom_addr = pc;
        end
        S_MEM_RD: begin
          ram_req  = 1'b1;
          ram_addr = operand;
        end
        S_MEM_WR: begin
          ram_req   = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = operand;
          ram_wdata = wr_lat ? a_reg : stk_rdata;
        end
        S_POP_A, S_POP_B: stk_pop = 1'b1;
        S_WB: begin
          alu_op    = opcode;
          alu_a     = a_reg;
          alu_b     = b_reg;
          stk_push  = 1'b1;
          stk_wdata = alu_result;
        end
        S_BR: if (cls == C_COND) begin
          alu_op = opcode;
          alu_a  = a_reg;
        end
        S_PUSH_W: begin
          stk_push  = 1'b1;
          stk_wdata = a_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl_unit.sv
// Directed bench for stack_ctrl_unit: a direct-branch instance for most
// programs and an indirect-branch instance for the RAM-target branches.
module tb_stack_ctrl_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset1, reset2;
  logic rom_stall, ram_stall, flag_drv, sel;

  logic [9:0]  rom [0:31];
  logic [15:0] ram_init [0:31];
  logic [15:0] ram_wr [0:31];
  bit          ram_wv [0:31];
  logic [15:0] stk1 [0:31];
  logic [15:0] stk2 [0:31];

  // DUT 1 (direct branches)
  logic        rom_req1, rom_ready1, ram_req1, ram_we1, ram_ready1;
  logic [4:0]  rom_addr1, ram_addr1, alu_op1, stk_ptr1;
  logic [9:0]  rom_data1;
  logic [15:0] ram_wdata1, ram_rdata1, stk_wdata1, stk_rdata1, alu_a1, alu_b1, alu_result1;
  logic        stk_push1, stk_pop1, alu_flag1, halted1, fault1;
  // DUT 2 (indirect branches)
  logic        rom_req2, rom_ready2, ram_req2, ram_we2, ram_ready2;
  logic [4:0]  rom_addr2, ram_addr2, alu_op2, stk_ptr2;
  logic [9:0]  rom_data2;
  logic [15:0] ram_wdata2, ram_rdata2, stk_wdata2, stk_rdata2, alu_a2, alu_b2, alu_result2;
  logic        stk_push2, stk_pop2, alu_flag2, halted2, fault2;

  stack_ctrl_unit #(.DATA_W(16), .ADDR_W(5), .OPC_W(5), .STACK_DEPTH(16), .BRANCH_INDIRECT(0)) dut (
    .clock(clock), .reset(reset1),
    .rom_req(rom_req1), .rom_addr(rom_addr1), .rom_ready(rom_ready1), .rom_data(rom_data1),
    .ram_req(ram_req1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .ram_ready(ram_ready1),
    .stk_push(stk_push1), .stk_pop(stk_pop1), .stk_wdata(stk_wdata1), .stk_rdata(stk_rdata1),
    .stk_ptr(stk_ptr1), .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_result(alu_result1), .alu_flag(alu_flag1), .halted(halted1), .fault(fault1)
  );

  stack_ctrl_unit #(.DATA_W(16), .ADDR_W(5), .OPC_W(5), .STACK_DEPTH(16), .BRANCH_INDIRECT(1)) dut_ind (
    .clock(clock), .reset(reset2),
    .rom_req(rom_req2), .rom_addr(rom_addr2), .rom_ready(rom_ready2), .rom_data(rom_data2),
    .ram_req(ram_req2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2), .ram_ready(ram_ready2),
    .stk_push(stk_push2), .stk_pop(stk_pop2), .stk_wdata(stk_wdata2), .stk_rdata(stk_rdata2),
    .stk_ptr(stk_ptr2), .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_result(alu_result2), .alu_flag(alu_flag2), .halted(halted2), .fault(fault2)
  );

  function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 5'd13) return ~a;
    return a + b;
  endfunction

  function automatic logic [9:0] ins(input int op, input int arg);
    logic [4:0] o, r;
    o = op[4:0];
    r = arg[4:0];
    return {o, r};
  endfunction

  // Memory, stack and ALU models
  assign rom_ready1  = rom_req1 && !rom_stall;
  assign rom_data1   = rom[rom_addr1];
  assign ram_ready1  = ram_req1 && !ram_stall;
  assign ram_rdata1  = ram_wv[ram_addr1] ? ram_wr[ram_addr1] : ram_init[ram_addr1];
  assign alu_result1 = alu_f(alu_op1, alu_a1, alu_b1);
  assign alu_flag1   = flag_drv;
  assign rom_ready2  = rom_req2 && !rom_stall;
  assign rom_data2   = rom[rom_addr2];
  assign ram_ready2  = ram_req2 && !ram_stall;
  assign ram_rdata2  = ram_wv[ram_addr2] ? ram_wr[ram_addr2] : ram_init[ram_addr2];
  assign alu_result2 = alu_f(alu_op2, alu_a2, alu_b2);
  assign alu_flag2   = flag_drv;

  always @(posedge clock) begin
    if (ram_req1 && ram_we1 && ram_ready1) begin
      ram_wr[ram_addr1] <= ram_wdata1;
      ram_wv[ram_addr1] <= 1'b1;
    end
    if (ram_req2 && ram_we2 && ram_ready2) begin
      ram_wr[ram_addr2] <= ram_wdata2;
      ram_wv[ram_addr2] <= 1'b1;
    end
    if (stk_push1) stk1[stk_ptr1] <= stk_wdata1;
    if (stk_pop1)  stk_rdata1 <= stk1[stk_ptr1 - 5'd1];
    if (stk_push2) stk2[stk_ptr2] <= stk_wdata2;
    if (stk_pop2)  stk_rdata2 <= stk2[stk_ptr2 - 5'd1];
  end

  logic       m_rom_req;
  logic [4:0] m_rom_addr;
  assign m_rom_req  = sel ? rom_req2 : rom_req1;
  assign m_rom_addr = sel ? rom_addr2 : rom_addr1;

  int checks = 0;
  int errors = 0;
  int n_push, n_pop, n_wr;
  logic [15:0] cap_w, cap_a, cap_b, cap_wdata;
  logic [4:0]  cap_waddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs from a FETCH cycle until the next FETCH (or the cycle bound).
  task automatic run_instr(input int bound, output int cyc);
    cyc = 0; n_push = 0; n_pop = 0; n_wr = 0;
    do begin
      tick();
      cyc++;
      if (stk_push1) begin
        n_push++; cap_w = stk_wdata1; cap_a = alu_a1; cap_b = alu_b1;
      end
      if (stk_pop1) n_pop++;
      if (ram_req1 && ram_we1) begin
        n_wr++; cap_waddr = ram_addr1; cap_wdata = ram_wdata1;
      end
    end while (!m_rom_req && cyc < bound);
  endtask

  initial begin
    int c;
    int bad;
    reset1 = 1'b1; reset2 = 1'b1;
    rom_stall = 1'b0; ram_stall = 1'b0; flag_drv = 1'b0; sel = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rom[i] = ins(31, 0);
      ram_init[i] = 16'h0;
    end
    // Program 1: arithmetic, RAM round trip, NOT, temp, branches, wrap
    rom[0]  = ins(1, 5);   rom[1]  = ins(1, 3);   rom[2]  = ins(4, 0);
    rom[3]  = ins(3, 7);   rom[4]  = ins(0, 7);   rom[5]  = ins(13, 0);
    rom[6]  = ins(2, 0);   rom[7]  = ins(1, 0);   rom[8]  = ins(15, 20);
    rom[20] = ins(1, 0);   rom[21] = ins(15, 5);  rom[22] = ins(14, 30);
    rom[30] = ins(1, 1);   rom[31] = ins(1, 2);
    tick(); tick();
    check("reset_rom_req", 32'(rom_req1), 0);
    check("reset_sp", 32'(stk_ptr1), 0);
    check("reset_flags", 32'({halted1, fault1}), 0);
    reset1 = 1'b0;
    #1;
    check("first_fetch_req", 32'(rom_req1), 1);
    check("first_fetch_addr", 32'(rom_addr1), 0);

    run_instr(20, c); check("push_i_cycles", c, 3); check("push_i_data", 32'(cap_w), 5);
    run_instr(20, c);
    check("sp_after_two", 32'(stk_ptr1), 2);
    run_instr(20, c);
    check("add_cycles", c, 6);
    check("add_pops", n_pop, 2);
    check("add_alu_a", 32'(cap_a), 5);
    check("add_alu_b", 32'(cap_b), 3);
    check("add_result", 32'(cap_w), 8);
    check("add_sp", 32'(stk_ptr1), 1);
    check("add_pc", 32'(rom_addr1), 3);

    run_instr(20, c);
    check("pop_cycles", c, 4);
    check("pop_waddr", 32'(cap_waddr), 7);
    check("pop_wdata", 32'(cap_wdata), 8);
    check("pop_sp", 32'(stk_ptr1), 0);
    run_instr(20, c);
    check("pushm_cycles", c, 4);
    check("pushm_data", 32'(cap_w), 8);
    check("pushm_sp", 32'(stk_ptr1), 1);

    run_instr(20, c);
    check("not_cycles", c, 5);
    check("not_alu_b", 32'(cap_b), 0);
    check("not_result", 32'(cap_w), 32'h0000FFF7);
    run_instr(20, c);
    check("pusht_cycles", c, 3);
    check("pusht_data", 32'(cap_w), 32'h0000FFF7);

    run_instr(20, c);
    flag_drv = 1'b1;
    run_instr(20, c);
    check("br_taken_cycles", c, 5);
    check("br_taken_pc", 32'(rom_addr1), 20);
    check("br_taken_sp", 32'(stk_ptr1), 2);
    flag_drv = 1'b0;
    run_instr(20, c);
    run_instr(20, c);
    check("br_not_taken_cycles", c, 5);
    check("br_not_taken_pc", 32'(rom_addr1), 22);
    run_instr(20, c);
    check("goto_cycles", c, 3);
    check("goto_pc", 32'(rom_addr1), 30);

    // ROM wait states at pc=30
    rom_stall = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(rom_req1 === 1'b1 && rom_addr1 === 5'd30)) bad++;
      if (i < 3) tick();
    end
    check("rom_wait_stable", bad, 0);
    rom_stall = 1'b0;
    run_instr(20, c);
    check("rom_wait_cycles", c, 3);
    check("pc_31", 32'(rom_addr1), 31);
    run_instr(20, c);
    check("pc_wrap", 32'(rom_addr1), 0);
    check("wrap_sp", 32'(stk_ptr1), 4);

    // Overflow: 17 pushes into a 16-deep stack
    reset1 = 1'b1;
    for (int i = 0; i < 17; i++) rom[i] = ins(1, i);
    tick(); tick();
    reset1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      run_instr(20, c);
      if (c != 3) bad++;
    end
    check("ovf_fill_cycles", bad, 0);
    check("ovf_full_sp", 32'(stk_ptr1), 16);
    check("ovf_pc", 32'(rom_addr1), 16);
    run_instr(12, c);
    check("ovf_no_fetch", c, 12);
    check("ovf_no_push", n_push, 0);
    check("ovf_fault", 32'(fault1), 1);
    check("ovf_sp", 32'(stk_ptr1), 16);

    // Underflow: binary op with one entry
    reset1 = 1'b1;
    rom[0] = ins(1, 1); rom[1] = ins(4, 0);
    tick(); tick();
    check("reset_clears_fault", 32'(fault1), 0);
    reset1 = 1'b0;
    run_instr(20, c);
    run_instr(12, c);
    check("udf_no_pop", n_pop, 0);
    check("udf_fault", 32'(fault1), 1);
    check("udf_sp", 32'(stk_ptr1), 1);

    // Reset during MEM_RD, then HALT
    reset1 = 1'b1;
    rom[0] = ins(0, 3);
    tick(); tick();
    ram_stall = 1'b1;
    reset1 = 1'b0;
    tick(); tick();
    check("memrd_req", 32'({ram_req1, ram_we1}), 32'h2);
    check("memrd_addr", 32'(ram_addr1), 3);
    tick();
    check("memrd_held", 32'({ram_req1, ram_addr1}), 32'h23);
    reset1 = 1'b1;
    tick();
    check("abort_outputs", 32'({rom_req1, ram_req1, stk_push1, stk_pop1}), 0);
    check("abort_sp", 32'(stk_ptr1), 0);
    rom[0] = ins(31, 0);
    ram_stall = 1'b0;
    reset1 = 1'b0;
    #1;
    check("restart_fetch", 32'({rom_req1, rom_addr1}), 32'h20);
    run_instr(12, c);
    check("halt_no_fetch", c, 12);
    check("halt_flags", 32'({halted1, fault1}), 32'h2);

    // Indirect branches on the second instance
    reset1 = 1'b1;
    sel = 1'b1;
    rom[0] = ins(1, 0); rom[1] = ins(15, 20); rom[9] = ins(14, 12);
    ram_init[20] = 16'd9; ram_init[12] = 16'd4;
    flag_drv = 1'b1;
    tick();
    reset2 = 1'b0;
    #1;
    check("ind_first_addr", 32'({rom_req2, rom_addr2}), 32'h20);
    run_instr(20, c);
    run_instr(20, c);
    check("ind_br_cycles", c, 6);
    check("ind_br_pc", 32'(m_rom_addr), 9);
    run_instr(20, c);
    check("ind_goto_cycles", c, 4);
    check("ind_goto_pc", 32'(m_rom_addr), 4);
    check("ind_flags", 32'({halted2, fault2}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
